// File: rtl/genetico_fitness_eval.sv
// Fitness evaluator: sweeps all 2^IN vectors into the logic grid and counts output bits matching a target table.
// Latency: done is high in cycle 1+NV*(SETTLE+1) after start is accepted (earlier when EVAL_EARLY_ABORT_EN aborts).
// Backpressure: none; start is only sampled in IDLE and ignored while busy. Optional feature macro: EVAL_EARLY_ABORT_EN.
module genetico_fitness_eval #(
    parameter int IN     = 4,
    parameter int OUT    = 4,
    parameter int SETTLE = 2,
    parameter int NV     = 2**IN,
    parameter int FW     = $clog2(OUT*NV+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [OUT-1:0][NV-1:0] target,
    output logic [IN-1:0]          circ_inp,
    input  logic [OUT-1:0]         circ_out,
    output logic                   busy,
    output logic                   done,
    output logic [FW-1:0]          fitness,
    output logic                   perfect
`ifdef EVAL_EARLY_ABORT_EN
    ,
    input  logic [FW-1:0]          max_err,
    output logic                   aborted
`endif
);

    localparam int SW = $clog2(SETTLE+1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [OUT-1:0][NV-1:0] target_q;
    logic [IN-1:0]          vec;
    logic [SW-1:0]          settle_cnt;
    logic [FW-1:0]          match_cnt;
    logic [FW-1:0]          fit_sum;
    logic                   last_vec;
    logic                   settle_end;
    logic                   over_limit;

`ifdef EVAL_EARLY_ABORT_EN
    logic [FW-1:0]          err_q;
    logic [FW-1:0]          max_err_q;
    logic [FW-1:0]          err_sum;
`endif

    // Count grid output bits that agree with the captured target column for the current vector.
    always_comb begin
        match_cnt = '0;
        for (int k = 0; k < OUT; k++) begin
            match_cnt = match_cnt + FW'(circ_out[k] == target_q[k][vec]);
        end
    end

    assign fit_sum    = fitness + match_cnt;
    // Explicit last-vector compare keeps the IN-bit vector counter from wrapping before the check.
    assign last_vec   = (vec == IN'(NV-1));
    assign settle_end = (settle_cnt == SW'(SETTLE-1));

`ifdef EVAL_EARLY_ABORT_EN
    assign err_sum    = err_q + (FW'(OUT) - match_cnt);
    assign over_limit = (err_sum > max_err_q);
`else
    assign over_limit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: settle for SETTLE cycles, sample once, repeat until the last vector (or abort).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_end) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (last_vec || over_limit) ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            circ_inp   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fitness    <= '0;
            perfect    <= 1'b0;
`ifdef EVAL_EARLY_ABORT_EN
            err_q      <= '0;
            max_err_q  <= '0;
            aborted    <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_q   <= target;
                        fitness    <= '0;
                        perfect    <= 1'b0;
                        vec        <= '0;
                        settle_cnt <= '0;
                        circ_inp   <= '0;
`ifdef EVAL_EARLY_ABORT_EN
                        err_q      <= '0;
                        max_err_q  <= max_err;
                        aborted    <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    fitness <= fit_sum;
`ifdef EVAL_EARLY_ABORT_EN
                    err_q   <= err_sum;
                    aborted <= over_limit;
`endif
                    if (last_vec || over_limit) begin
                        perfect <= (fit_sum == FW'(OUT*NV)) && !over_limit;
                    end else begin
                        vec      <= vec + 1'b1;
                        circ_inp <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_genetico_fitness_eval.sv
module tb_genetico_fitness_eval;

    localparam int IN     = 2;
    localparam int OUT    = 1;
    localparam int SETTLE = 2;
    localparam int NV     = 4;
    localparam int FW     = 3;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [OUT-1:0][NV-1:0] target;
    logic [IN-1:0]          circ_inp;
    logic [OUT-1:0]         circ_out;
    logic                   busy;
    logic                   done;
    logic [FW-1:0]          fitness;
    logic                   perfect;
    logic [3:0]             grid_tt;
`ifdef EVAL_EARLY_ABORT_EN
    logic [FW-1:0]          max_err;
    logic                   aborted;
`endif

    int checks   = 0;
    int failures = 0;

    genetico_fitness_eval #(.IN(IN), .OUT(OUT), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .circ_inp (circ_inp),
        .circ_out (circ_out),
        .busy     (busy),
        .done     (done),
        .fitness  (fitness),
        .perfect  (perfect)
`ifdef EVAL_EARLY_ABORT_EN
        ,
        .max_err  (max_err),
        .aborted  (aborted)
`endif
    );

    // Grid model: a lookup table indexed by the driven vector (XOR for the directed tests).
    assign circ_out = grid_tt[circ_inp];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: number of vectors where the grid output equals the target bit.
    function automatic int ref_fitness(input logic [3:0] tt, input logic [3:0] tgt);
        int f = 0;
        for (int v = 0; v < NV; v++) if (tt[v] == tgt[v]) f++;
        return f;
    endfunction

    // One full evaluation with trace checks; optional target change and stray start pulses mid-run.
    task automatic run_eval(input logic [3:0] tgt, input int tchg, input int p1, input int p2);
        int exp_fit;
        exp_fit = ref_fitness(grid_tt, tgt);
        target  = tgt;
        start   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            start = (c == p1) || (c == p2);
            if (c == tchg) target = 4'b0000;
            if (c <= 12) begin
                chk("sweep_trace", {busy, done, circ_inp}, {1'b1, 1'b0, 2'((c - 1) / 3)});
            end else if (c == 13) begin
                chk("done_pulse", {busy, done}, 2'b01);
                chk("fitness", fitness, exp_fit);
                chk("perfect", perfect, (exp_fit == 4) ? 1 : 0);
`ifdef EVAL_EARLY_ABORT_EN
                chk("aborted_full", aborted, 0);
`endif
            end else begin
                chk("hold_after_done", {busy, done, fitness, perfect},
                    {2'b00, 3'(exp_fit), (exp_fit == 4) ? 1'b1 : 1'b0});
            end
        end
    endtask

    initial begin
        int c;
        bit seen;
        logic [3:0] rt;
        rst     = 1'b1;
        start   = 1'b0;
        target  = '0;
        grid_tt = 4'b0110;
`ifdef EVAL_EARLY_ABORT_EN
        max_err = '1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, circ_inp, fitness, perfect}, 0);
`ifdef EVAL_EARLY_ABORT_EN
        chk("reset_aborted", aborted, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Matching target, partial target, stray start pulses, target change mid-run.
        run_eval(4'b0110, -1, -1, -1);
        run_eval(4'b1110, -1, -1, -1);
        run_eval(4'b0110, -1, 5, 9);
        run_eval(4'b0110, 4, -1, -1);

        // Start held high: one run, then a new run accepted the cycle after done.
        target = 4'b0110;
        start  = 1'b1;
        @(posedge clk);
        c = 0; seen = 0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            if (done === 1'b1) seen = 1;
        end
        chk("hold_done_cycle", c, 13);
        @(negedge clk);
        chk("hold_gap_cycle", {busy, done}, 2'b00);
        @(negedge clk);
        chk("hold_restart", {busy, circ_inp}, 3'b100);
        start = 1'b0;
        c = 15; seen = 0;
        while (!seen && c < 60) begin
            @(negedge clk); c++;
            if (done === 1'b1) seen = 1;
        end
        chk("hold_done2_cycle", c, 27);
        chk("hold_fitness2", {fitness, perfect}, {3'd4, 1'b1});
        @(negedge clk);

        // Reset mid-run: asserted during cycle 7, outputs cleared in cycle 8, no done afterwards.
        target = 4'b0110;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset", {busy, done, circ_inp, fitness, perfect}, 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("after_reset_idle", {busy, done, circ_inp}, 0);
        end
        run_eval(4'b0110, -1, -1, -1);

        // Randomized grids and targets against the reference count.
        for (int i = 0; i < 8; i++) begin
            grid_tt = 4'($urandom);
            rt      = 4'($urandom);
            run_eval(rt, -1, -1, -1);
        end
        grid_tt = 4'b0110;

`ifdef EVAL_EARLY_ABORT_EN
        // Early abort on the first mismatch with zero error budget.
        max_err = '0;
        target  = 4'b1111;
        start   = 1'b1;
        @(posedge clk);
        c = 0; seen = 0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            start = 1'b0;
            if (done === 1'b1) seen = 1;
        end
        chk("abort_done_cycle", c, 4);
        chk("abort_result", {aborted, fitness, perfect}, {1'b1, 3'd0, 1'b0});
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_extra_done", {busy, done}, 2'b00);
        end
        // Budget of 2 errors tolerates the two mismatches: full sweep.
        max_err = 3'd2;
        run_eval(4'b1111, -1, -1, -1);
        max_err = '1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
